spi_cfg_ctrl: RTL
=================

Name: spi_cfg_ctrl

Overview:
SPI-slave transaction controller that sits directly after the SPI input synchronizer/edge detector and drives the FIR configuration register bank. It frames transactions on the synchronized chip-select fall and assembles an 8-bit command (R/W and address) followed by one WORD_W data word. It issues single-cycle register write or read strobes and shifts read data out on miso (SPI mode 0, MSB first).

Parameters:
WORD_W, 16, data word width in bits.
ADDR_W, 7, register address width; the command is 1 + ADDR_W = 8 bits.

Ports:
clk  in  1  system clock.
n_rst  in  1  asynchronous active-low reset.
nss_fall  in  1  one-cycle pulse when synchronized nss falls; starts a frame.
rise_edge  in  1  one-cycle pulse on synchronized sck rise; the sample point.
fall_edge  in  1  one-cycle pulse on synchronized sck fall; the shift-out point.
mosi_s  in  1  synchronized mosi, valid when rise_edge is high.
rd_data  in  WORD_W  register bank read data, valid the cycle after rd_en.
wr_en  out  1  one-cycle register write strobe.
rd_en  out  1  one-cycle register read strobe.
addr  out  ADDR_W  register address, held from command completion until the next command completes.
wr_data  out  WORD_W  write data, held until the next write.
miso  out  1  serial read data.
busy  out  1  high from nss_fall until the transaction completes.
frame_err  out  1  one-cycle pulse when a frame is aborted by nss_fall.

Behaviour:
- Reset (async, n_rst low): all outputs 0, state IDLE, bit_cnt 0, shift registers 0.
- Clocking and sampling:
  - All logic runs on posedge clk.
  - sck must be no faster than clk/8. The bench does not check behaviour outside that limit.
  - mosi_s is shifted into rx_sr (left shift, MSB first) on each rise_edge, in CMD and DATA only.
- States:
  - IDLE: edges ignored. nss_fall -> CMD, clear bit_cnt, busy=1.
  - CMD: each rise_edge shifts and increments bit_cnt. On the 8th rise: latch addr = cmd[6:0] and rw = cmd[7], clear bit_cnt.
    - rw=1 -> DATA.
    - rw=0 -> RD_REQ.
  - RD_REQ (1 cycle): rd_en=1 -> RD_LOAD.
  - RD_LOAD (1 cycle): tx_sr <= rd_data -> DATA.
  - DATA: each rise_edge shifts rx_sr and increments bit_cnt.
    - On the WORD_W-th rise with rw=1: wr_data <= rx_sr (including the new bit), -> WR_STB.
    - On the WORD_W-th rise with rw=0: -> DONE.
  - WR_STB (1 cycle): wr_en=1 -> DONE.
  - DONE: busy=0, edges ignored. nss_fall -> CMD.
- miso:
  - miso = tx_sr[WORD_W-1] in DATA when rw=0; otherwise 0.
  - In DATA with rw=0, a fall_edge shifts tx_sr left (0 fill) only when bit_cnt > 0. This puts the MSB on miso before the first data rise and ignores the fall edge that follows the last command bit.
- Latency:
  - wr_en asserts 2 clk cycles after the final data rise_edge.
  - rd_en asserts 1 clk cycle after the final command rise_edge.
- Abort: nss_fall while in CMD, RD_REQ, RD_LOAD, DATA or WR_STB:
  - frame_err pulse in the same cycle.
  - Restart in CMD with bit_cnt cleared; busy stays 1.
  - A pending wr_en in WR_STB is suppressed. addr and wr_data keep their last completed values.
- Simultaneous nss_fall and rise_edge: nss_fall wins; the bit is dropped.
- rise_edge and fall_edge are mutually exclusive by construction; no arbitration needed.
- bit_cnt width is $clog2(WORD_W+1). It never wraps because it clears on each phase change.

Decomposition:
- Package spi_cfg_pkg holds:
  - state enum state_t {IDLE, CMD, RD_REQ, RD_LOAD, DATA, WR_STB, DONE};
  - CMD_W = 8;
  - RW_BIT = 7.
- One natural sub-module, spi_shift_reg (parameterized width, load, shift_en, serial in, parallel out, MSB out). Instantiate it twice, for rx and tx.

Test Plan:
- Write: nss_fall, cmd 0x85, data 0xBEEF over 24 rise edges -> one wr_en pulse with addr=0x05, wr_data=0xBEEF, 2 clk after the last rise; busy falls in the same cycle wr_en drops.
- Read: cmd 0x03, rd_data=0xA55A returned the cycle after rd_en -> rd_en pulses once with addr=0x03; miso bits sampled on 16 rises = 1010010101011010; no wr_en.
- Abort: nss_fall after 12 bits of a write -> frame_err pulse, no wr_en. A following full write of cmd 0x81, data 0x1234 -> wr_en with addr=0x01, wr_data=0x1234.
- Idle noise: 20 rise/fall edges with no nss_fall after reset, then in DONE -> no strobes, busy=0, miso=0.
- Reset mid-DATA: assert n_rst low asynchronously between clk edges -> all outputs 0 immediately. A new transaction after release completes normally.
- Back-to-back: write 0x82/0x0001, then nss_fall in DONE, then read 0x02 with rd_data 0x0001 -> miso shifts out 0000000000000001.

Source files
------------

// File: rtl/spi_cfg_pkg.sv
// rtl/spi_cfg_pkg.sv - shared states and command framing constants for spi_cfg_ctrl
package spi_cfg_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    RD_REQ,
    RD_LOAD,
    DATA,
    WR_STB,
    DONE
  } state_t;

  localparam int CMD_W  = 8;
  localparam int RW_BIT = 7;

endpackage

// File: rtl/spi_shift_reg.sv
// rtl/spi_shift_reg.sv - MSB-first shift register with parallel load
module spi_shift_reg #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         load,
  input  logic [W-1:0] load_data,
  input  logic         shift_en,
  input  logic         sin,
  output logic [W-1:0] q,
  output logic         msb
);

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      q <= '0;
    end else if (load) begin
      q <= load_data;
    end else if (shift_en) begin
      q <= {q[W-2:0], sin};
    end
  end

  assign msb = q[W-1];

endmodule

// File: rtl/spi_cfg_ctrl.sv
// rtl/spi_cfg_ctrl.sv - SPI-slave command/data framer driving register write and read strobes
module spi_cfg_ctrl
  import spi_cfg_pkg::*;
#(
  parameter int WORD_W = 16,
  parameter int ADDR_W = 7
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              nss_fall,
  input  logic              rise_edge,
  input  logic              fall_edge,
  input  logic              mosi_s,
  input  logic [WORD_W-1:0] rd_data,
  output logic              wr_en,
  output logic              rd_en,
  output logic [ADDR_W-1:0] addr,
  output logic [WORD_W-1:0] wr_data,
  output logic              miso,
  output logic              busy,
  output logic              frame_err
);

  localparam int CNT_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] CMD_LAST  = CNT_W'(CMD_W - 1);
  localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(WORD_W - 1);

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic               rw;
  logic [WORD_W-1:0]  rx_q;
  logic               tx_msb;
  logic [CMD_W-1:0]   cmd;
  logic               rx_shift;
  logic               tx_load;
  logic               tx_shift;

  // Command byte as it will look once the bit on mosi_s is shifted in.
  assign cmd      = {rx_q[CMD_W-2:0], mosi_s};
  assign rx_shift = rise_edge && !nss_fall && (state == CMD || state == DATA);
  assign tx_load  = (state == RD_LOAD) && !nss_fall;
  // The fall right after the last command bit arrives with bit_cnt 0 and must not shift.
  assign tx_shift = (state == DATA) && !rw && fall_edge && (bit_cnt != '0) && !nss_fall;
  assign miso     = (state == DATA && !rw) ? tx_msb : 1'b0;

  spi_shift_reg #(.W(WORD_W)) u_rx_sr (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (1'b0),
    .load_data ('0),
    .shift_en  (rx_shift),
    .sin       (mosi_s),
    .q         (rx_q),
    .msb       ()
  );

  spi_shift_reg #(.W(WORD_W)) u_tx_sr (
    .clk       (clk),
    .n_rst     (n_rst),
    .load      (tx_load),
    .load_data (rd_data),
    .shift_en  (tx_shift),
    .sin       (1'b0),
    .q         (),
    .msb       (tx_msb)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      rw        <= 1'b0;
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      addr      <= '0;
      wr_data   <= '0;
      busy      <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      wr_en     <= 1'b0;
      rd_en     <= 1'b0;
      frame_err <= 1'b0;
      if (nss_fall) begin
        // A new frame always wins, aborting whatever was in flight.
        state     <= CMD;
        bit_cnt   <= '0;
        busy      <= 1'b1;
        frame_err <= (state != IDLE) && (state != DONE);
      end else begin
        case (state)
          IDLE: ;
          CMD: begin
            if (rise_edge) begin
              if (bit_cnt == CMD_LAST) begin
                addr    <= cmd[ADDR_W-1:0];
                rw      <= cmd[RW_BIT];
                bit_cnt <= '0;
                if (cmd[RW_BIT]) begin
                  state <= DATA;
                end else begin
                  state <= RD_REQ;
                  rd_en <= 1'b1;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          RD_REQ:  state <= RD_LOAD;
          RD_LOAD: state <= DATA;
          DATA: begin
            if (rise_edge) begin
              if (bit_cnt == DATA_LAST) begin
                bit_cnt <= '0;
                if (rw) begin
                  wr_data <= {rx_q[WORD_W-2:0], mosi_s};
                  state   <= WR_STB;
                end else begin
                  state <= DONE;
                end
              end else begin
                bit_cnt <= bit_cnt + 1'b1;
              end
            end
          end
          WR_STB: begin
            wr_en <= 1'b1;
            state <= DONE;
          end
          DONE:    busy <= 1'b0;
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
